// File: rtl/vec_alu_pkg.sv
// vec_alu_pkg -- shared constants for the vector ALU lane.
//   OP_*      : RVV funct6 encodings understood by the lane
//   state_e   : lane sequencer states
//   SEW_*     : vsew encodings (SEW = 8 << vsew)
//   sew_clamp : folds reserved vsew values 4..7 onto 64-bit elements
// Optional feature macro: VEC_ALU_ARITH_EN (enables vadd/vsub).
package vec_alu_pkg;

    localparam logic [5:0] OP_VADD = 6'b000000;
    localparam logic [5:0] OP_VSUB = 6'b000010;
    localparam logic [5:0] OP_VAND = 6'b001001;
    localparam logic [5:0] OP_VOR  = 6'b001010;
    localparam logic [5:0] OP_VXOR = 6'b001011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam logic [2:0] SEW_8  = 3'd0;
    localparam logic [2:0] SEW_16 = 3'd1;
    localparam logic [2:0] SEW_32 = 3'd2;
    localparam logic [2:0] SEW_64 = 3'd3;

    function automatic logic [1:0] sew_clamp(input logic [2:0] vsew);
        logic [1:0] r;
        case (vsew)
            SEW_8:   r = 2'd0;
            SEW_16:  r = 2'd1;
            SEW_32:  r = 2'd2;
            SEW_64:  r = 2'd3;
            default: r = 2'd3;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/vec_alu_chunk_op.sv
// vec_alu_chunk_op -- combinational operation on one lane chunk.
//   op_i    : funct6 opcode
//   a_i     : chunk of vs2 (minuend / first operand)
//   b_i     : chunk of vs1
//   carry_i : carry (vadd) or borrow (vsub) from the previous sub-chunk
//   carry_o : carry/borrow out of this chunk
//   res_o   : chunk result (zero for unsupported opcodes)
// Optional feature macro: VEC_ALU_ARITH_EN. Without it the carry ports do
// not exist and vadd/vsub fall into the zero-result default.
module vec_alu_chunk_op #(
    parameter int unsigned CW = 16
) (
    input  logic [5:0]    op_i,
    input  logic [CW-1:0] a_i,
    input  logic [CW-1:0] b_i,
`ifdef VEC_ALU_ARITH_EN
    input  logic          carry_i,
    output logic          carry_o,
`endif
    output logic [CW-1:0] res_o
);
    import vec_alu_pkg::*;

`ifdef VEC_ALU_ARITH_EN
    logic [CW:0] sum;
`endif

    always_comb begin
        res_o = '0;
`ifdef VEC_ALU_ARITH_EN
        carry_o = 1'b0;
        sum     = '0;
`endif
        case (op_i)
            OP_VAND: res_o = a_i & b_i;
            OP_VOR:  res_o = a_i | b_i;
            OP_VXOR: res_o = a_i ^ b_i;
`ifdef VEC_ALU_ARITH_EN
            OP_VADD: begin
                sum     = {1'b0, a_i} + {1'b0, b_i} + {{CW{1'b0}}, carry_i};
                res_o   = sum[CW-1:0];
                carry_o = sum[CW];
            end
            // The extension bit of a (CW+1)-bit difference is set exactly
            // when the chunk underflowed, i.e. it is the borrow out.
            OP_VSUB: begin
                sum     = {1'b0, a_i} - {1'b0, b_i} - {{CW{1'b0}}, carry_i};
                res_o   = sum[CW-1:0];
                carry_o = sum[CW];
            end
`endif
            default: res_o = '0;
        endcase
    end

endmodule

// File: rtl/vec_alu.sv
// vec_alu -- one lane of a multi-lane vector ALU. Each step writes one
// W-bit chunk of vd; elements are interleaved across (1<<NB_LANES) lanes.
//   clk, resetn      : clock, async active-low reset
//   opcode, vsew     : funct6 and element width, latched when run rises
//   run              : start/continue; low aborts to idle
//   vs1, vs2         : source vectors, sampled live every step
//   vd               : result register, one chunk updated per step
//   reg_index        : bit offset of the chunk written this cycle
//   done             : last chunk of this lane has been produced
// Optional feature macro: VEC_ALU_ARITH_EN (vadd/vsub and carry flop).
//
// state   | meaning
// IDLE    | waiting for run; the start edge already produces step 0
// BUSY    | one chunk per edge using latched opcode/vsew
// DONE    | all chunks written; outputs held until run drops
module vec_alu #(
    parameter int unsigned VLEN       = 128,
    parameter int unsigned LANE_WIDTH = 3'b100,
    parameter int unsigned NB_LANES   = 2'b01,
    parameter int unsigned LANE_I     = 3'b000
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [5:0]      opcode,
    input  logic            run,
    input  logic [VLEN-1:0] vs1,
    input  logic [VLEN-1:0] vs2,
    input  logic [2:0]      vsew,
    output logic [VLEN-1:0] vd,
    output logic [9:0]      reg_index,
    output logic            done
);
    import vec_alu_pkg::*;

    localparam int unsigned WMAX     = 1 << LANE_WIDTH;
    localparam logic [2:0]  LW       = 3'(LANE_WIDTH);
    localparam logic [3:0]  VLOG     = 4'($clog2(VLEN));
    localparam logic [3:0]  NBL      = 4'(NB_LANES);
    localparam logic [9:0]  LANE_IDX = 10'(LANE_I);

    state_e          state_q;
    logic [5:0]      op_q;
    logic [1:0]      sew_q;
    logic [9:0]      step_q;
    logic [VLEN-1:0] vd_q;
    logic [VLEN-1:0] vd_d;
    logic [9:0]      idx_q;
    logic            done_q;

    logic            idle;
    logic [5:0]      op_cur;
    logic [1:0]      sew_cur;
    logic [9:0]      step_cur;
    logic [2:0]      sew_log;
    logic [2:0]      w_log;
    logic [2:0]      sub_log;
    logic [3:0]      n_log;
    logic [9:0]      last_step;
    logic [9:0]      sub_idx;
    logic [9:0]      elem_k;
    logic [9:0]      elem;
    logic [9:0]      idx_cur;
    logic [6:0]      w_bits;
    logic [WMAX-1:0] cmask;
    logic [WMAX-1:0] chunk_a;
    logic [WMAX-1:0] chunk_b;
    logic [WMAX-1:0] chunk_res;
    logic [VLEN-1:0] wmask;
    logic            is_last;

`ifdef VEC_ALU_ARITH_EN
    logic            carry_q;
    logic            carry_in;
    logic            carry_out;
`endif

    assign idle = (state_q == ST_IDLE);

    // The start edge uses the live opcode/vsew; later steps use the
    // latched copies so mid-operation changes are ignored.
    always_comb begin
        op_cur    = idle ? opcode : op_q;
        sew_cur   = idle ? sew_clamp(vsew) : sew_q;
        step_cur  = idle ? '0 : step_q;
        sew_log   = {1'b0, sew_cur} + 3'd3;
        w_log     = (sew_log > LW) ? LW : sew_log;
        sub_log   = sew_log - w_log;
        n_log     = VLOG - {1'b0, w_log} - NBL;
        last_step = (10'd1 << n_log) - 10'd1;
        // step = k * (SEW/W) + sub; this lane owns elements k*lanes + LANE_I
        sub_idx   = step_cur & ((10'd1 << sub_log) - 10'd1);
        elem_k    = step_cur >> sub_log;
        elem      = (elem_k << NBL) | LANE_IDX;
        idx_cur   = (elem << sew_log) + (sub_idx << w_log);
        is_last   = (step_cur == last_step);
        w_bits    = 7'd1 << w_log;
        cmask     = ~({WMAX{1'b1}} << w_bits);
        chunk_a   = WMAX'(vs2 >> idx_cur);
        chunk_b   = WMAX'(vs1 >> idx_cur);
        wmask     = VLEN'(cmask) << idx_cur;
        vd_d      = (vd_q & ~wmask) | (VLEN'(chunk_res & cmask) << idx_cur);
    end

`ifdef VEC_ALU_ARITH_EN
    // Carry chain restarts at the first sub-chunk of every element.
    assign carry_in = (sub_idx == '0) ? 1'b0 : carry_q;
`endif

    vec_alu_chunk_op #(
        .CW (WMAX)
    ) u_chunk_op (
        .op_i    (op_cur),
        .a_i     (chunk_a),
        .b_i     (chunk_b),
`ifdef VEC_ALU_ARITH_EN
        .carry_i (carry_in),
        .carry_o (carry_out),
`endif
        .res_o   (chunk_res)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            sew_q   <= '0;
            step_q  <= '0;
            vd_q    <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
`ifdef VEC_ALU_ARITH_EN
            carry_q <= 1'b0;
`endif
        end else if (!run) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_BUSY: begin
                    if (idle) begin
                        op_q  <= opcode;
                        sew_q <= sew_clamp(vsew);
                    end
                    vd_q   <= vd_d;
                    idx_q  <= idx_cur;
                    step_q <= step_cur + 10'd1;
`ifdef VEC_ALU_ARITH_EN
                    carry_q <= carry_out;
`endif
                    if (is_last) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= ST_BUSY;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign vd        = vd_q;
    assign reg_index = idx_q;
    assign done      = done_q;

endmodule

// File: tb/tb_vec_alu.sv
// tb_vec_alu -- two-lane bench for vec_alu with a scoreboard queue: the
// driver pushes the expected merged vd per operation, a monitor pops and
// compares when both lanes raise done.
module tb_vec_alu;

    localparam logic [5:0] T_VADD = 6'b000000;
    localparam logic [5:0] T_VSUB = 6'b000010;
    localparam logic [5:0] T_VAND = 6'b001001;
    localparam logic [5:0] T_VOR  = 6'b001010;
    localparam logic [5:0] T_VXOR = 6'b001011;
    localparam logic [5:0] T_BAD  = 6'b111111;

    localparam logic [127:0] VS1     = 128'habcdabcdbeefbeef1234567887654321;
    localparam logic [127:0] VS2     = 128'h8765432112345678beefbeefabcdabcd;
    localparam logic [127:0] EXP_AND = 128'h83450301122416681224166883450301;
    localparam logic [127:0] EXP_OR  = 128'hafedebedbefffeffbefffeffafedebed;
    localparam logic [127:0] EXP_XOR = 128'h2ca8e8ecacdbe897acdbe8972ca8e8ec;

    localparam logic [127:0] ADD_VS2 = {64'h000000000000ffff, 64'h00000000ffffffff};
    localparam logic [127:0] ADD_VS1 = {64'h0000000000010001, 64'h0000000000000001};
    localparam logic [127:0] SUB_VS2 = 128'h070500;
    localparam logic [127:0] SUB_VS1 = 128'h030201;
`ifdef VEC_ALU_ARITH_EN
    localparam logic [127:0] EXP_ADD = {64'h0000000000020000, 64'h0000000100000000};
    localparam logic [127:0] EXP_SUB = 128'h0403ff;
`else
    localparam logic [127:0] EXP_ADD = '0;
    localparam logic [127:0] EXP_SUB = '0;
`endif

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         run = 1'b0;
    logic [5:0]   opcode = '0;
    logic [2:0]   vsew = '0;
    logic [127:0] vs1 = '0;
    logic [127:0] vs2 = '0;
    logic [127:0] vd0, vd1;
    logic [9:0]   ri0, ri1;
    logic         done0, done1;

    always #5 clk = ~clk;

    vec_alu #(.VLEN(128), .LANE_WIDTH(4), .NB_LANES(1), .LANE_I(0)) u_lane0 (
        .clk(clk), .resetn(resetn), .opcode(opcode), .run(run),
        .vs1(vs1), .vs2(vs2), .vsew(vsew),
        .vd(vd0), .reg_index(ri0), .done(done0)
    );

    vec_alu #(.VLEN(128), .LANE_WIDTH(4), .NB_LANES(1), .LANE_I(1)) u_lane1 (
        .clk(clk), .resetn(resetn), .opcode(opcode), .run(run),
        .vs1(vs1), .vs2(vs2), .vsew(vsew),
        .vd(vd1), .reg_index(ri1), .done(done1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string        name;
        logic [127:0] vd;
    } exp_t;

    exp_t sbq[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int sew_eff(input logic [2:0] s);
        return (s > 3'd3) ? 3 : int'(s);
    endfunction

    function automatic int w_of(input logic [2:0] s);
        int l;
        l = sew_eff(s) + 3;
        if (l > 4) l = 4;
        return 1 << l;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        run    = 1'b0;
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic do_op(input string name, input logic [5:0] op, input logic [2:0] sew,
                         input logic [127:0] a1, input logic [127:0] a2,
                         input logic [127:0] exp, input bit rst_first, input bit chg_mid);
        int w;
        int n;
        int bad;
        int hits[128];
        w = w_of(sew);
        n = 128 / w / 2;
        if (rst_first) do_reset();
        foreach (hits[c]) hits[c] = 0;
        sbq.push_back('{name, exp});
        @(negedge clk);
        opcode = op;
        vsew   = sew;
        vs1    = a1;
        vs2    = a2;
        run    = 1'b1;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) begin
                chk({name, "_first_idx_l0"}, 128'(ri0), 128'(0));
                chk({name, "_first_idx_l1"}, 128'(ri1), 128'(8 << sew_eff(sew)));
                if (chg_mid) begin
                    opcode = T_VAND;
                    vsew   = 3'd0;
                end
            end
            hits[ri0 / w]++;
            hits[ri1 / w]++;
            chk({name, "_done_l0"}, 128'(done0), 128'(i == n));
            chk({name, "_done_l1"}, 128'(done1), 128'(i == n));
        end
        bad = 0;
        for (int c = 0; c < 128; c++) begin
            if (c < 128 / w) bad += (hits[c] != 1) ? 1 : 0;
            else             bad += (hits[c] != 0) ? 1 : 0;
        end
        chk({name, "_chunk_cover"}, 128'(bad), 128'(0));
        @(posedge clk);
        #1;
        chk({name, "_hold_done"}, 128'(done0 & done1), 128'(1));
        chk({name, "_hold_vd"}, vd0 | vd1, exp);
        @(negedge clk);
        run = 1'b0;
        @(posedge clk);
        #1;
        chk({name, "_idle_done"}, 128'(done0 | done1), 128'(0));
    endtask

    // Monitor: one scoreboard entry per operation, consumed when both
    // lanes report done.
    initial begin
        exp_t e;
        bit   prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (done0 && done1 && !prev) begin
                if (sbq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_unexpected_done: got done with empty queue, required none");
                end else begin
                    e = sbq.pop_front();
                    chk({e.name, "_vd"}, vd0 | vd1, e.vd);
                end
            end
            prev = done0 && done1;
        end
    end

    initial begin
        #1;
        chk("reset_vd", vd0 | vd1, 128'(0));
        chk("reset_idx", 128'({ri0, ri1}), 128'(0));
        chk("reset_done", 128'({done0, done1}), 128'(0));
        @(negedge clk);
        resetn = 1'b1;

        do_op("and_sew0", T_VAND, 3'd0, VS1, VS2, EXP_AND, 1'b1, 1'b0);
        do_op("and_sew1", T_VAND, 3'd1, VS1, VS2, EXP_AND, 1'b1, 1'b0);
        do_op("and_sew2", T_VAND, 3'd2, VS1, VS2, EXP_AND, 1'b1, 1'b0);
        do_op("and_sew3", T_VAND, 3'd3, VS1, VS2, EXP_AND, 1'b1, 1'b0);
        do_op("or_sew1", T_VOR, 3'd1, VS1, VS2, EXP_OR, 1'b1, 1'b0);
        do_op("xor_sew7_chg", T_VXOR, 3'd7, VS1, VS2, EXP_XOR, 1'b1, 1'b1);
        do_op("and_pre_bad", T_VAND, 3'd1, VS1, VS2, EXP_AND, 1'b1, 1'b0);
        do_op("bad_opcode", T_BAD, 3'd1, VS1, VS2, 128'(0), 1'b0, 1'b0);
        do_op("add_sew3", T_VADD, 3'd3, ADD_VS1, ADD_VS2, EXP_ADD, 1'b1, 1'b0);
        do_op("sub_sew0", T_VSUB, 3'd0, SUB_VS1, SUB_VS2, EXP_SUB, 1'b1, 1'b0);

        // Abort after three edges, then restart from step 0.
        do_reset();
        @(negedge clk);
        opcode = T_VAND;
        vsew   = 3'd0;
        vs1    = VS1;
        vs2    = VS2;
        run    = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            #1;
            chk("abort_done_running", 128'(done0 | done1), 128'(0));
        end
        @(negedge clk);
        run = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("abort_done_idle", 128'(done0 | done1), 128'(0));
        end
        do_op("and_restart", T_VAND, 3'd0, VS1, VS2, EXP_AND, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a cycle, mid-operation.
        do_reset();
        @(negedge clk);
        opcode = T_VAND;
        vsew   = 3'd3;
        run    = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        #2;
        resetn = 1'b0;
        #1;
        chk("async_rst_vd", vd0 | vd1, 128'(0));
        chk("async_rst_idx", 128'({ri0, ri1}), 128'(0));
        chk("async_rst_done", 128'({done0, done1}), 128'(0));
        run = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        do_op("and_after_rst", T_VAND, 3'd2, VS1, VS2, EXP_AND, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        chk("sb_empty", 128'(sbq.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
